// File: rtl/rr_mux8_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux8_arbiter_pkg
//   Shared definitions for the 8-way round-robin mux arbiter: requester count,
//   select width and the two-state controller encoding.
// ---------------------------------------------------------------------------
package rr_mux8_arbiter_pkg;

    localparam int NREQ = 8;
    localparam int SELW = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_mux8_arbiter_mux8.sv
// ---------------------------------------------------------------------------
// mux8
//   Plain 8:1 N-bit combinational multiplexer for the arbiter datapath.
// Ports:
//   d0..d7  in  N     data inputs
//   s       in  SELW  select
//   y       out N     selected data
// ---------------------------------------------------------------------------
module mux8
    import rr_mux8_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]    d0,
    input  logic [N-1:0]    d1,
    input  logic [N-1:0]    d2,
    input  logic [N-1:0]    d3,
    input  logic [N-1:0]    d4,
    input  logic [N-1:0]    d5,
    input  logic [N-1:0]    d6,
    input  logic [N-1:0]    d7,
    input  logic [SELW-1:0] s,
    output logic [N-1:0]    y
);

    always_comb begin
        case (s)
            3'd0:    y = d0;
            3'd1:    y = d1;
            3'd2:    y = d2;
            3'd3:    y = d3;
            3'd4:    y = d4;
            3'd5:    y = d5;
            3'd6:    y = d6;
            default: y = d7;
        endcase
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux8_arbiter
//   Round-robin arbiter and sequencer in front of a shared 8:1 N-bit mux.
//   One requester at a time is granted; its beats are moved to the consumer
//   with a valid/ready handshake. A grant ends on a last beat, after BURST
//   beats (BURST=0: unlimited) or when the requester withdraws. Every grant
//   is followed by exactly one IDLE cycle.
// Ports:
//   clk        in   1     clock, rising edge
//   reset      in   1     asynchronous, active-high reset
//   req        in   8     per-requester beat valid
//   last       in   8     per-requester end-of-packet flag
//   din        in   8*N   flattened data, requester i owns din[i*N +: N]
//   out_ready  in   1     downstream accepts a beat
//   out_valid  out  1     out_data holds a valid beat
//   out_data   out  N     data of the selected requester
//   sel        out  3     registered index of the granted requester
//   ack        out  8     one-hot beat-consumed strobe
//   busy       out  1     controller is in GRANT
// ---------------------------------------------------------------------------
module rr_mux8_arbiter
    import rr_mux8_arbiter_pkg::*;
#(
    parameter int N     = 32,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     last,
    input  logic [NREQ*N-1:0]   din,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [N-1:0]        out_data,
    output logic [SELW-1:0]     sel,
    output logic [NREQ-1:0]     ack,
    output logic                busy
);

    // Counter width clog2(BURST)+1; it saturates rather than wraps, which
    // matters only in unlimited mode (BURST=0).
    localparam int              CNTW     = $clog2(BURST) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    arb_state_e      state_q, state_d;
    logic [SELW-1:0] ptr_q,   ptr_d;
    logic [SELW-1:0] sel_q,   sel_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;

    logic xfer;
    logic rel;

    // First requesting index scanning circularly from p. Only meaningful
    // when r is non-zero; the caller guarantees that.
    function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [SELW-1:0] p);
        logic [SELW-1:0] idx;
        logic            found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = p + SELW'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rel       = 1'b0;
        ack       = '0;

        // Output decode uses the registered state only, so an asynchronous
        // reset drops out_valid/ack without waiting for a clock edge.
        out_valid = (state_q == ST_GRANT) && req[sel_q];
        xfer      = out_valid && out_ready;
        ack[sel_q] = xfer;

        case (state_q)
            ST_IDLE: begin
                // Requests seen during GRANT are only considered here, which
                // also produces the mandatory one-cycle bubble between grants.
                if (|req) begin
                    sel_d   = rr_pick(req, ptr_q);
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                rel = !req[sel_q] ||
                      (xfer && (last[sel_q] || ((BURST != 0) && (cnt_q == CNT_LAST))));
                if (rel) begin
                    state_d = ST_IDLE;
                    ptr_d   = sel_q + SELW'(1);   // 7 wraps to 0 naturally
                    cnt_d   = '0;
                end else if (xfer && (cnt_q != CNT_MAX)) begin
                    cnt_d   = cnt_q + CNTW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel  = sel_q;
    assign busy = (state_q == ST_GRANT);

    mux8 #(.N(N)) u_mux8 (
        .d0 (din[0*N +: N]),
        .d1 (din[1*N +: N]),
        .d2 (din[2*N +: N]),
        .d3 (din[3*N +: N]),
        .d4 (din[4*N +: N]),
        .d5 (din[5*N +: N]),
        .d6 (din[6*N +: N]),
        .d7 (din[7*N +: N]),
        .s  (sel_q),
        .y  (out_data)
    );

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux8_arbiter
//   Directed scenarios with hand-computed expectations, then randomized
//   traffic, all checked every cycle against a behavioural arbiter model.
// ---------------------------------------------------------------------------
module tb_rr_mux8_arbiter;

    localparam int N     = 32;
    localparam int BURST = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      req;
    logic [7:0]      last;
    logic [8*N-1:0]  din;
    logic            out_ready;
    logic            out_valid;
    logic [N-1:0]    out_data;
    logic [2:0]      sel;
    logic [7:0]      ack;
    logic            busy;

    int total = 0;
    int bad   = 0;

    rr_mux8_arbiter #(.N(N), .BURST(BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .din       (din),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = granted requester, or -1 while idle.
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_beats;

    function automatic logic exp_valid();
        return (m_owner >= 0) && req[m_owner];
    endfunction

    function automatic logic [7:0] exp_ack();
        logic [7:0] a;
        a = '0;
        if (exp_valid() && out_ready) a[m_owner] = 1'b1;
        return a;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int pick;
        if (reset) begin
            m_owner <= -1;
            m_sel   <= 0;
            m_ptr   <= 0;
            m_beats <= 0;
        end else if (m_owner < 0) begin
            pick = -1;
            for (int k = 0; k < 8; k++)
                if (pick < 0 && req[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
            if (pick >= 0) begin
                m_owner <= pick;
                m_sel   <= pick;
                m_beats <= 0;
            end
        end else if (!req[m_owner]) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % 8;
        end else if (out_ready) begin
            if (last[m_owner] || (BURST != 0 && m_beats + 1 == BURST)) begin
                m_owner <= -1;
                m_ptr   <= (m_owner + 1) % 8;
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("m_out_valid", 64'(out_valid), 64'(exp_valid()));
            check("m_ack",       64'(ack),       64'(exp_ack()));
            check("m_busy",      64'(busy),      64'(m_owner >= 0));
            check("m_sel",       64'(sel),       64'(m_sel));
            check("m_out_data",  64'(out_data),  64'(din[m_sel*N +: N]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req       = '0;
        last      = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        at_neg();
        at_neg();
        reset = 1'b0;
        tick();
    endtask

    logic [7:0] acked;

    initial begin
        reset     = 1'b1;
        req       = '0;
        last      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) din[i*N +: N] = $urandom();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_ack",       64'(ack),       64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_sel",       64'(sel),       64'(0));
        check("rst_out_data",  64'(out_data),  64'(din[0 +: N]));

        // 1: single one-beat packet from requester 0
        do_reset();
        req = 8'h01; last = 8'h01; out_ready = 1'b1;
        at_neg();
        check("t1_arb_latency", 64'(out_valid), 64'(0));
        at_neg();
        check("t1_sel",       64'(sel),       64'(0));
        check("t1_out_valid", 64'(out_valid), 64'(1));
        check("t1_ack",       64'(ack),       64'(8'h01));
        tick();
        req = 8'h00;
        at_neg();
        check("t1_idle_busy", 64'(busy), 64'(0));
        check("t1_idle_ack",  64'(ack),  64'(0));

        // 2: all requesting, one-beat packets -> 0..7,0 with bubbles
        do_reset();
        req = 8'hFF; last = 8'hFF; out_ready = 1'b1;
        for (int g = 0; g < 9; g++) begin
            at_neg();
            check("t2_bubble", 64'(busy), 64'(0));
            at_neg();
            check("t2_sel", 64'(sel), 64'(g % 8));
            check("t2_ack", 64'(ack), 64'(8'h01 << (g % 8)));
        end
        tick();
        req = 8'h00;

        // 3: burst limit on requester 3, then 5 wins over 3
        do_reset();
        req = 8'h28; last = 8'h00; out_ready = 1'b1;
        at_neg();
        for (int b = 0; b < 4; b++) begin
            at_neg();
            check("t3_sel", 64'(sel), 64'(3));
            check("t3_ack", 64'(ack), 64'(8'h08));
        end
        at_neg();
        check("t3_forced_release", 64'(busy), 64'(0));
        at_neg();
        check("t3_next_sel", 64'(sel), 64'(5));
        check("t3_next_ack", 64'(ack), 64'(8'h20));

        // 4: back-pressure on requester 2
        do_reset();
        din[2*N +: N] = 32'hCAFE_0002;
        req = 8'h04; last = 8'h04; out_ready = 1'b0;
        at_neg();
        for (int c = 0; c < 3; c++) begin
            at_neg();
            check("t4_valid", 64'(out_valid), 64'(1));
            check("t4_ack",   64'(ack),       64'(0));
            check("t4_data",  64'(out_data),  64'(32'hCAFE_0002));
        end
        tick();
        out_ready = 1'b1;
        at_neg();
        check("t4_ack_on_ready", 64'(ack), 64'(8'h04));

        // 5: requester 6 withdraws, scan then wraps 7 -> 0
        do_reset();
        req = 8'h40; last = 8'h00; out_ready = 1'b0;
        at_neg();
        at_neg();
        check("t5_sel",   64'(sel),       64'(6));
        check("t5_valid", 64'(out_valid), 64'(1));
        tick();
        req = 8'h01; out_ready = 1'b1;
        at_neg();
        check("t5_withdraw_valid", 64'(out_valid), 64'(0));
        check("t5_withdraw_ack",   64'(ack),       64'(0));
        check("t5_withdraw_busy",  64'(busy),      64'(1));
        tick();
        req = 8'h41;
        at_neg();
        check("t5_bubble", 64'(busy), 64'(0));
        at_neg();
        check("t5_wrap_sel", 64'(sel), 64'(0));
        check("t5_wrap_ack", 64'(ack), 64'(8'h01));

        // 6: async reset during a grant, pointer cleared
        do_reset();
        req = 8'h04; last = 8'h04; out_ready = 1'b1;
        at_neg();
        at_neg();
        tick();
        req = 8'h10; last = 8'h00;
        at_neg();
        at_neg();
        check("t6_pre_sel",   64'(sel),       64'(4));
        check("t6_pre_valid", 64'(out_valid), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'(0));
        check("t6_rst_ack",   64'(ack),       64'(0));
        check("t6_rst_busy",  64'(busy),      64'(0));
        check("t6_rst_sel",   64'(sel),       64'(0));
        at_neg();
        reset = 1'b0;
        req   = 8'h82;
        tick();
        at_neg();
        check("t6_ptr_zero_sel", 64'(sel), 64'(1));

        // Randomized traffic; beats held stable until acked or withdrawn.
        do_reset();
        acked = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 8; i++) begin
                if (req[i] && !acked[i]) begin
                    if ($urandom_range(15) == 0) req[i] = 1'b0;
                end else begin
                    req[i]        = ($urandom_range(2) == 0);
                    last[i]       = ($urandom_range(3) == 0);
                    din[i*N +: N] = $urandom();
                end
            end
            out_ready = ($urandom_range(3) != 0);
            at_neg();
            acked = exp_ack();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
